// File: rtl/aes_inv_cipher_core_if.sv
// Bus interface for aes_inv_cipher_core.
//   start  : request to decrypt ct (requester -> core)
//   ct     : 128-bit ciphertext, byte k at bits 8k..8k+7
//   rk_idx : round-key index the core needs this cycle (core -> key store)
//   rk     : round key for rk_idx, combinational from the key store
//   busy   : operation in progress
//   done   : one-cycle pulse, pt valid
//   pt     : 128-bit plaintext, held until the next accepted start
interface aes_inv_cipher_core_if;
  logic         start;
  logic [0:127] ct;
  logic [3:0]   rk_idx;
  logic [0:127] rk;
  logic         busy;
  logic         done;
  logic [0:127] pt;

  modport master (output start, ct, rk, input rk_idx, busy, done, pt);
  modport slave  (input start, ct, rk, output rk_idx, busy, done, pt);
endinterface

// File: rtl/aes_inv_cipher_core.sv
// AES-128 inverse cipher, one round per clock.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : aes_inv_cipher_core_if.slave (start/ct in, rk_idx out, rk in,
//         busy/done/pt out)
// Round keys come from an external combinational store addressed by rk_idx:
// key 10 is consumed on start, 9..1 in ROUND, 0 in FINAL.
module aes_inv_cipher_core (
  input  logic                  clk,
  input  logic                  rst,
  aes_inv_cipher_core_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  state_t       r_fsm;
  state_t       w_fsm_nxt;
  logic [3:0]   r_rnd;
  logic [0:127] r_state;
  logic [0:127] r_pt;

  logic [0:127] w_isr;
  logic [0:127] w_isb;
  logic [0:127] w_ark;
  logic [0:127] w_imc;
  logic [3:0]   w_rk_idx;
  logic         w_busy;
  logic         w_done;

  // Byte (row r, col c) sits at index 4c+r; row r rotates right by r.
  function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = s[8*(4*((c+4-r)%4)+r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [0:127] inv_sub_bytes(input logic [0:127] s);
    logic [0:127] o;
    logic [7:0]   b;
    o = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      b = s[8*k +: 8];
      o[8*k +: 8] = INV_SBOX[{b, 3'b000} +: 8];
    end
    return o;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by a 4-bit constant k, built from doublings.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
           (k[1] ? x2 : 8'h00) ^ (k[0] ? a  : 8'h00);
  endfunction

  function automatic logic [0:127] inv_mix_columns(input logic [0:127] s);
    logic [0:127] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[32*c      +: 8];
      a1 = s[32*c + 8  +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      o[32*c      +: 8] = gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9);
      o[32*c + 8  +: 8] = gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd);
      o[32*c + 16 +: 8] = gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb);
      o[32*c + 24 +: 8] = gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he);
    end
    return o;
  endfunction

  assign w_isr = inv_shift_rows(r_state);
  assign w_isb = inv_sub_bytes(w_isr);
  assign w_ark = w_isb ^ bus.rk;
  assign w_imc = inv_mix_columns(w_ark);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fsm <= IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    w_rk_idx  = 4'd10;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    case (r_fsm)
      IDLE: begin
        if (bus.start) w_fsm_nxt = ROUND;
      end
      ROUND: begin
        w_rk_idx = r_rnd;
        w_busy   = 1'b1;
        if (r_rnd == 4'd1) w_fsm_nxt = FINAL;
      end
      FINAL: begin
        w_rk_idx  = 4'd0;
        w_busy    = 1'b1;
        w_fsm_nxt = DONE;
      end
      DONE: begin
        w_done    = 1'b1;
        w_fsm_nxt = IDLE;
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rnd   <= '0;
      r_state <= '0;
      r_pt    <= '0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (bus.start) begin
            r_state <= bus.ct ^ bus.rk;
            r_rnd   <= 4'd9;
          end
        end
        ROUND: begin
          r_state <= w_imc;
          r_rnd   <= r_rnd - 4'd1;
        end
        FINAL: r_pt <= w_ark;
        default: ;
      endcase
    end
  end

  assign bus.rk_idx = w_rk_idx;
  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.pt     = r_pt;

endmodule

// File: doc/aes_inv_cipher_core.md
AES_INV_CIPHER_CORE -- requirements
Module: aes_inv_cipher_core

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The module SHALL have port start, input, 1 bit: request to decrypt ct; sampled only in IDLE.
REQ-004 The module SHALL have port ct, input, [0:127]: ciphertext, sampled with start; byte k occupies bits 8k:8k+7; state byte (row r, column c) is byte 4c+r.
REQ-005 The module SHALL have port rk_idx, output, 4 bits: round-key index requested this cycle, driven combinationally from state.
REQ-006 The module SHALL have port rk, input, [0:127]: round key for rk_idx, valid in the same cycle (external combinational key store, AES-128 expansion, index 0..10).
REQ-007 The module SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-008 The module SHALL have port done, output, 1 bit: one-cycle pulse when pt is valid.
REQ-009 The module SHALL have port pt, output, [0:127]: plaintext, held stable from done until the next accepted start.

Function
REQ-010 The module SHALL implement InvShiftRows as out byte 4c+r = in byte 4((c-r) mod 4)+r, for r,c in 0..3, with row 0 unchanged.
REQ-011 The module SHALL implement InvSubBytes (FIPS-197 inverse S-box, per byte), AddRoundKey (128-bit XOR with rk) and InvMixColumns (FIPS-197 matrix 0e 0b 0d 09, per column), all combinational within one cycle.
REQ-012 The FSM SHALL have exactly the states IDLE, ROUND, FINAL, DONE, and SHALL hold a 4-bit round counter rnd.
REQ-013 In IDLE, rk_idx SHALL be 10; on a clock edge with start=1, the state register SHALL load ct XOR rk, rnd SHALL load 9, and the FSM SHALL move to ROUND.
REQ-014 In ROUND, rk_idx SHALL equal rnd; each edge SHALL update state to InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk)) and decrement rnd; when rnd=1 the FSM SHALL move to FINAL.
REQ-015 In FINAL, rk_idx SHALL be 0; the edge SHALL load pt with AddRoundKey(InvSubBytes(InvShiftRows(state)), rk) and move the FSM to DONE.
REQ-016 In DONE, done SHALL be 1 and busy SHALL be 0 for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-017 Latency: with start sampled at edge E0, done SHALL be high in the cycle following edge E10 (9 ROUND edges plus 1 FINAL edge).
REQ-018 busy SHALL be 1 in ROUND and FINAL and 0 in IDLE and DONE.
REQ-019 start SHALL be ignored in ROUND, FINAL and DONE; no queuing; pt SHALL be unaffected.
REQ-020 A start asserted in the same cycle as done SHALL be ignored; a start in the following IDLE cycle SHALL be accepted.
REQ-021 Holding start high continuously SHALL produce back-to-back operations with one IDLE cycle between each done and the next acceptance.
REQ-022 pt SHALL change only on the FINAL edge or on reset.

Reset
REQ-023 While rst=1, regardless of clk, the FSM SHALL be IDLE, rnd=0, the state register=0, pt=0, busy=0 and done=0.
REQ-024 A reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after deassertion SHALL decrypt normally.
REQ-025 rk_idx SHALL read 10 during and immediately after reset.

Verification
REQ-026 The bench SHALL cover: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff, with done exactly 11 cycles after start.
REQ-027 The bench SHALL cover: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734, with rk_idx sequence 10,9,...,1,0.
REQ-028 The bench SHALL cover: start pulsed at cycles 3 and 7 of an operation with a different ct -> those pulses are ignored and pt equals the first vector's plaintext.
REQ-029 The bench SHALL cover: rst asserted at ROUND with rnd=5 -> busy=0, pt=0 and no done pulse; the REQ-026 vector rerun after reset passes.
REQ-030 The bench SHALL cover: start held high for two operations with vectors A then B -> two done pulses 12 cycles apart, each with the correct pt.
REQ-031 The bench SHALL cover: a unit check of InvShiftRows with input bytes 00..0f -> output 00 0d 0a 07 04 01 0e 0b 08 05 02 0f 0c 09 06 03.
